alu_system_sequencer: RTL
=========================

Name: alu_system_sequencer

Overview:
- Hardwired fetch/decode/execute controller that drives every select/enable input of alu_system.
- Fetches a 16-bit instruction as two bytes through memory → instruction_register, then issues one execute cycle.
- Sits beside alu_system: consumes IROut and ALU flags, produces all control words.
- Memory reads are combinational, so read data is valid in the cycle CS is asserted.

Parameters:
- PC_SEL, 3'b100, RegSel_arf/OutDSel-coded selector of PC (OutDSel uses 2'b00 for PC, 2'b01 for AR).
- ALU_PASS_A, 5'b10000, FunSel5 code for "ALUOut = A" (32-bit pass-through).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  leave IDLE/HALT and begin fetching.
- IROut  in  16  instruction register contents.
- flags  in  8  ALU flags; flags[7] = Z.
- RegSel_rf  out  4  RF one-hot load enable; bit3 = R1 … bit0 = R4.
- FunSel3  out  3  RF function; 3'b010 load, 3'b000 hold.
- OutASel, OutBSel  out  3 each  RF read selects.
- MuxASel, MuxBSel  out  2 each  11 = IR low byte.
- MuxCSel  out  2  ALU byte to memory.
- MuxDSel  out  1  0 = RF OutA.
- FunSel5  out  5  ALU function.
- RegSel_arf  out  3  ARF one-hot load enable.
- FunSel2_arf  out  2  01 increment, 10 load, 00 hold.
- OutDSel  out  2  memory address source.
- LH  out  1  IR half select; 0 = low byte.
- write  out  1  IR write enable.
- CS  out  1  memory select, active-low.
- WR  out  1  1 = memory write.
- busy  out  1  high in F0/F1/DEC/EX.
- halted  out  1  high in HALT.
- instr_count  out  16  retired instructions.

Behaviour:
Idle and reset values:
- Idle defaults, applied in every state unless overridden: RegSel_rf=0, RegSel_arf=0, FunSel3=000, FunSel2_arf=00, write=0, CS=1, WR=0, all muxes/selects=0, FunSel5=ALU_PASS_A.
- reset (sync) → state=IDLE, instr_count=0, all outputs at idle defaults; busy=0, halted=0.
- Reset wins over every other input, including mid-fetch or mid-execute; no partial effects occur after the reset edge.

States: IDLE, F0, F1, DEC, EX, HALT.
- IDLE: start=1 → F0; otherwise stay.
- F0: CS=0, WR=0, OutDSel=00, LH=0, write=1, RegSel_arf=PC_SEL, FunSel2_arf=01 (PC++). → F1.
- F1: same as F0 but LH=1. → DEC.
- DEC: all outputs idle; gives IROut one cycle to settle. → EX.
- EX, keyed on op=IROut[15:12]; Rd=IROut[11:10]:
  - 0 NOP: no action.
  - 1 LDI: RegSel_rf = 4'b1000>>Rd, FunSel3=010, MuxASel=11.
  - 2 ALU: OutASel=IROut[6:4], OutBSel=IROut[3:1], MuxDSel=0, FunSel5={2'b10, IROut[9:7]}, MuxASel=00, RegSel_rf = 4'b1000>>Rd, FunSel3=010.
  - 3 ST: OutASel=IROut[6:4], FunSel5=ALU_PASS_A, MuxCSel=00, OutDSel=01, CS=0, WR=1.
  - 4 JMP: MuxBSel=11, RegSel_arf=PC_SEL, FunSel2_arf=10.
  - 5 BZ: same as JMP only when flags[7]=1; otherwise no action. flags is sampled in EX.
  - F HALT: → HALT.
  - All other opcodes behave as NOP.
- EX, non-HALT: instr_count += 1 (wraps 16'hFFFF → 0), then → F0.
- EX, HALT opcode: instr_count += 1, then → HALT.
- HALT: outputs idle, halted=1; start=1 → F0; instr_count is kept.
- start is ignored outside IDLE/HALT.

Timing and outputs:
- Outputs are a registered state decode, combinational from state and IROut; no glitch constraint is imposed.
- Latency: 4 cycles per instruction (F0, F1, DEC, EX).
- First F0 occurs on the cycle after start is sampled.
- PC advances by 2 per fetch. A JMP overrides the PC in EX; it does not compete with PC++ because PC++ occurs only in F0/F1.
- Simultaneous reset and start: reset wins.

Test Plan:
1. reset high 2 cycles, then low with start=0 for 3 cycles → state IDLE, CS=1, write=0, busy=0, instr_count=0.
2. start pulse; memory bytes 0x2A (PC=0) and 0x14 (PC=1) → IROut=16'h142A, op 1, Rd=1.
   - Required: RegSel_rf=4'b0100, MuxASel=11 in EX (cycle 4).
   - Required: instr_count=1; PC incremented twice; next fetch at PC=2.
3. Instruction 16'h2128 (ALU, Rd=0, fn=010, A=010, B=100) → in EX: FunSel5=5'b10010, OutASel=010, OutBSel=100, RegSel_rf=4'b1000, FunSel3=010.
4. Branch on Z, instruction 16'h5010:
   - flags[7]=1 → RegSel_arf=3'b100, FunSel2_arf=10, MuxBSel=11.
   - flags[7]=0 → RegSel_arf=0; next fetch at PC+2.
5. Store, then halt:
   - ST 16'h3020 → CS=0, WR=1, OutDSel=01 for exactly one cycle.
   - Next instruction 16'hF000 → halted=1 and busy=0 after EX.
   - start → F0 with instr_count preserved.
6. Assert reset during F1 → next cycle IDLE, write=0, CS=1, instr_count=0; with instr_count=16'hFFFF, a retiring NOP wraps it to 0.

Source files
------------

// File: rtl/alu_system_sequencer.sv
// -----------------------------------------------------------------------------
// alu_system_sequencer
//
// Hardwired fetch/decode/execute controller for alu_system. It fetches a
// 16-bit instruction as two bytes (low byte first) from memory into the
// instruction register. It waits one decode cycle so that IROut settles. It
// then issues a single execute cycle. All datapath select/enable words are
// produced here.
//
// Every instruction takes four cycles: F0, F1, DEC, EX. IDLE and HALT wait
// for start.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high; wins over everything
//   start        in   1   leave IDLE/HALT and begin fetching
//   IROut        in  16   instruction register contents
//   flags        in   8   ALU flags, flags[7] = Z
//   RegSel_rf    out  4   RF one-hot load enable (bit3 = R1 ... bit0 = R4)
//   FunSel3      out  3   RF function (010 load, 000 hold)
//   OutASel      out  3   RF read select A
//   OutBSel      out  3   RF read select B
//   MuxASel      out  2   RF input mux (11 = IR low byte)
//   MuxBSel      out  2   ARF input mux (11 = IR low byte)
//   MuxCSel      out  2   ALU byte routed to memory
//   MuxDSel      out  1   ALU A input (0 = RF OutA)
//   FunSel5      out  5   ALU function
//   RegSel_arf   out  3   ARF one-hot load enable
//   FunSel2_arf  out  2   ARF function (01 inc, 10 load, 00 hold)
//   OutDSel      out  2   memory address source (00 PC, 01 AR)
//   LH           out  1   IR half select (0 = low byte)
//   write        out  1   IR write enable
//   CS           out  1   memory chip select, active-low
//   WR           out  1   memory write (1 = write)
//   busy         out  1   high in F0/F1/DEC/EX
//   halted       out  1   high in HALT
//   instr_count  out 16   retired instructions, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module alu_system_sequencer #(
    parameter logic [2:0] PC_SEL     = 3'b100,
    parameter logic [4:0] ALU_PASS_A = 5'b10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] IROut,
    input  logic [7:0]  flags,
    output logic [3:0]  RegSel_rf,
    output logic [2:0]  FunSel3,
    output logic [2:0]  OutASel,
    output logic [2:0]  OutBSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic [1:0]  MuxCSel,
    output logic        MuxDSel,
    output logic [4:0]  FunSel5,
    output logic [2:0]  RegSel_arf,
    output logic [1:0]  FunSel2_arf,
    output logic [1:0]  OutDSel,
    output logic        LH,
    output logic        write,
    output logic        CS,
    output logic        WR,
    output logic        busy,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_DEC  = 3'd3,
        ST_EX   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ALU  = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_BZ   = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    logic [15:0] r_instr_count;
    logic        r_busy;
    logic        r_halted;

    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic        w_zero;
    logic        w_unused_bits;

    assign w_op   = IROut[15:12];
    assign w_rd   = IROut[11:10];
    assign w_zero = flags[7];

    // IR bit 0 and the non-Z flags do not steer any control word
    assign w_unused_bits = ^{IROut[0], flags[6:0]};

    assign busy        = r_busy;
    assign halted      = r_halted;
    assign instr_count = r_instr_count;

    // Sequencer state, retired-instruction counter and registered status flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instr_count <= 16'h0000;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // start is only honoured while parked
                    if (start) begin
                        r_state  <= ST_F0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end else begin
                        r_state  <= r_state;
                    end
                end
                ST_F0: begin
                    r_state <= ST_F1;
                end
                ST_F1: begin
                    r_state <= ST_DEC;
                end
                ST_DEC: begin
                    r_state <= ST_EX;
                end
                ST_EX: begin
                    // HALT also retires, so the count includes it
                    r_instr_count <= r_instr_count + 16'h0001;
                    if (w_op == OP_HALT) begin
                        r_state  <= ST_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state  <= ST_F0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Control-word decode from the state register, IR contents and Z flag
    always_comb begin
        RegSel_rf   = 4'b0000;
        FunSel3     = 3'b000;
        OutASel     = 3'b000;
        OutBSel     = 3'b000;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 2'b00;
        MuxDSel     = 1'b0;
        FunSel5     = ALU_PASS_A;
        RegSel_arf  = 3'b000;
        FunSel2_arf = 2'b00;
        OutDSel     = 2'b00;
        LH          = 1'b0;
        write       = 1'b0;
        CS          = 1'b1;
        WR          = 1'b0;

        case (r_state)
            ST_F0, ST_F1: begin
                // Read the byte at PC into the selected IR half and bump PC.
                // The read is combinational, so the byte lands on this edge.
                CS          = 1'b0;
                WR          = 1'b0;
                OutDSel     = 2'b00;
                LH          = (r_state == ST_F1) ? 1'b1 : 1'b0;
                write       = 1'b1;
                RegSel_arf  = PC_SEL;
                FunSel2_arf = 2'b01;
            end
            ST_EX: begin
                case (w_op)
                    OP_LDI: begin
                        RegSel_rf = 4'b1000 >> w_rd;
                        FunSel3   = 3'b010;
                        MuxASel   = 2'b11;
                    end
                    OP_ALU: begin
                        OutASel   = IROut[6:4];
                        OutBSel   = IROut[3:1];
                        MuxDSel   = 1'b0;
                        FunSel5   = {2'b10, IROut[9:7]};
                        MuxASel   = 2'b00;
                        RegSel_rf = 4'b1000 >> w_rd;
                        FunSel3   = 3'b010;
                    end
                    OP_ST: begin
                        // Pass the register through the ALU and write its
                        // low byte to the address held in AR
                        OutASel = IROut[6:4];
                        FunSel5 = ALU_PASS_A;
                        MuxCSel = 2'b00;
                        OutDSel = 2'b01;
                        CS      = 1'b0;
                        WR      = 1'b1;
                    end
                    OP_JMP: begin
                        MuxBSel     = 2'b11;
                        RegSel_arf  = PC_SEL;
                        FunSel2_arf = 2'b10;
                    end
                    OP_BZ: begin
                        if (w_zero) begin
                            MuxBSel     = 2'b11;
                            RegSel_arf  = PC_SEL;
                            FunSel2_arf = 2'b10;
                        end else begin
                            RegSel_arf  = 3'b000;
                            FunSel2_arf = 2'b00;
                        end
                    end
                    OP_NOP, OP_HALT: begin
                        RegSel_rf = 4'b0000;
                    end
                    default: begin
                        RegSel_rf = 4'b0000;
                    end
                endcase
            end
            ST_IDLE, ST_DEC, ST_HALT: begin
                CS = 1'b1;
            end
            default: begin
                CS = 1'b1;
            end
        endcase
    end

endmodule
